// File: rtl/memory_stage.sv
`timescale 1ns/1ps
// Memory-access stage: issues single-outstanding Wishbone loads/stores for execute
// and forwards register-writeback results, stalling execute while a transfer is open.
module memory_stage #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int FUNCT_WIDTH  = 3,
  parameter int OPCODE_WIDTH = 11,
  parameter int LOAD_BIT     = 2,
  parameter int STORE_BIT    = 3
) (
  input  logic                    me_clk,
  input  logic                    me_rst,
  input  logic                    me_i_ce,
  input  logic                    me_i_stall,
  input  logic                    me_i_flush,
  input  logic [OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  me_i_funct3,
  input  logic [DWIDTH-1:0]       me_i_alu_value,
  input  logic [DWIDTH-1:0]       me_i_data_rs2,
  input  logic [AWIDTH-1:0]       me_i_addr_rd,
  input  logic                    me_i_we_reg,
  output logic                    me_o_wb_cyc,
  output logic                    me_o_wb_stb,
  output logic                    me_o_wb_we,
  output logic [DWIDTH-1:0]       me_o_wb_addr,
  output logic [DWIDTH-1:0]       me_o_wb_data,
  output logic [DWIDTH/8-1:0]     me_o_wb_sel,
  input  logic                    me_i_wb_ack,
  input  logic [DWIDTH-1:0]       me_i_wb_data,
  output logic                    me_o_stall,
  output logic                    me_o_ce,
  output logic                    me_o_we_reg,
  output logic [AWIDTH-1:0]       me_o_addr_rd,
  output logic [DWIDTH-1:0]       me_o_data_rd,
  output logic                    me_o_misaligned
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e                 state_q;
  logic                   cyc_q, stb_q, wb_we_q;
  logic [DWIDTH-1:0]      wb_addr_q, wb_data_q;
  logic [DWIDTH/8-1:0]    wb_sel_q;
  logic                   is_load_q;
  logic [FUNCT_WIDTH-1:0] funct3_q;
  logic [1:0]             off_q;
  logic [AWIDTH-1:0]      rd_cap_q;
  logic                   we_cap_q;
  logic                   squash_q;
  logic [DWIDTH-1:0]      buf_q;
  logic                   ce_q, we_reg_q, misaligned_q;
  logic [AWIDTH-1:0]      addr_rd_q;
  logic [DWIDTH-1:0]      data_rd_q;

  logic                   is_load, is_store, is_mem;
  logic [1:0]             off;
  logic                   f3_legal, misalign, access_bad;
  logic [DWIDTH/8-1:0]    st_sel;
  logic [DWIDTH-1:0]      st_data;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [DWIDTH-1:0]      ld_ext, ack_data, retire_data;
  logic                   retire, squash_now;
  logic                   unused_opcode_bits;

  assign is_load            = me_i_opcode[LOAD_BIT];
  assign is_store           = me_i_opcode[STORE_BIT];
  assign is_mem             = is_load | is_store;
  assign off                = me_i_alu_value[1:0];
  assign unused_opcode_bits = ^me_i_opcode;

  // Request decode: funct3 legality, alignment, and store lane/data replication.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    f3_legal = 1'b0;
    misalign = 1'b0;
    st_sel   = '0;
    st_data  = '0;
    case (me_i_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase
    case (me_i_funct3[1:0])
      2'b00: begin
        st_sel  = 4'b0001 << off;
        st_data = {4{me_i_data_rs2[7:0]}};
      end
      2'b01: begin
        misalign = off[0];
        st_sel   = off[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{me_i_data_rs2[15:0]}};
      end
      2'b10: begin
        misalign = (off != 2'b00);
        st_sel   = 4'b1111;
        st_data  = me_i_data_rs2;
      end
      default: ;
    endcase
  end

  assign access_bad = !f3_legal || misalign;

  // Load lane extraction uses the offset and size captured at acceptance.
  always_comb begin
    ld_byte = me_i_wb_data[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? me_i_wb_data[31:16] : me_i_wb_data[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(DWIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(DWIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(DWIDTH-16){1'b0}}, ld_half};
      default: ld_ext = me_i_wb_data;
    endcase
  end

  assign ack_data    = is_load_q ? ld_ext : '0;
  assign retire      = !me_i_stall && ((state_q == BUSY && me_i_wb_ack) || state_q == HOLD);
  assign retire_data = (state_q == HOLD) ? buf_q : ack_data;
  assign squash_now  = squash_q | me_i_flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge me_clk or negedge me_rst) begin
    if (!me_rst) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_sel_q     <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_cap_q     <= '0;
      we_cap_q     <= 1'b0;
      squash_q     <= 1'b0;
      buf_q        <= '0;
      ce_q         <= 1'b0;
      we_reg_q     <= 1'b0;
      misaligned_q <= 1'b0;
      addr_rd_q    <= '0;
      data_rd_q    <= '0;
    end else begin
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!me_i_stall) begin
            ce_q <= 1'b0;
            if (me_i_ce && !me_i_flush) begin
              if (!is_mem) begin
                ce_q      <= 1'b1;
                data_rd_q <= me_i_alu_value;
                addr_rd_q <= me_i_addr_rd;
                we_reg_q  <= me_i_we_reg;
              end else if (access_bad) begin
                ce_q         <= 1'b1;
                we_reg_q     <= 1'b0;
                misaligned_q <= 1'b1;
                addr_rd_q    <= me_i_addr_rd;
                data_rd_q    <= me_i_alu_value;
              end else begin
                cyc_q     <= 1'b1;
                stb_q     <= 1'b1;
                wb_we_q   <= !is_load;
                wb_addr_q <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
                wb_sel_q  <= is_load ? '1 : st_sel;
                wb_data_q <= is_load ? '0 : st_data;
                is_load_q <= is_load;
                funct3_q  <= me_i_funct3;
                off_q     <= off;
                rd_cap_q  <= me_i_addr_rd;
                we_cap_q  <= me_i_we_reg;
                state_q   <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          stb_q <= 1'b0;
          if (me_i_flush) squash_q <= 1'b1;
          if (me_i_wb_ack) begin
            cyc_q   <= 1'b0;
            buf_q   <= ack_data;
            state_q <= me_i_stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (me_i_flush) squash_q <= 1'b1;
          if (!me_i_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A flush seen at any point of the transaction turns the result into a bubble.
      if (retire) begin
        ce_q      <= !squash_now;
        we_reg_q  <= we_cap_q && is_load_q && !squash_now;
        addr_rd_q <= rd_cap_q;
        data_rd_q <= retire_data;
        squash_q  <= 1'b0;
      end
    end
  end

  assign me_o_wb_cyc     = cyc_q;
  assign me_o_wb_stb     = stb_q;
  assign me_o_wb_we      = wb_we_q;
  assign me_o_wb_addr    = wb_addr_q;
  assign me_o_wb_data    = wb_data_q;
  assign me_o_wb_sel     = wb_sel_q;
  assign me_o_stall      = (state_q != IDLE);
  assign me_o_ce         = ce_q;
  assign me_o_we_reg     = we_reg_q;
  assign me_o_addr_rd    = addr_rd_q;
  assign me_o_data_rd    = data_rd_q;
  assign me_o_misaligned = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
`timescale 1ns/1ps
// Bench for memory_stage: directed scenarios followed by randomized transactions,
// all checked against an arithmetic reference model of loads, stores and exceptions.
module tb_memory_stage;

  localparam logic [10:0] OP_ALU   = 11'b000_0000_0001;
  localparam logic [10:0] OP_LOAD  = 11'b000_0000_0100;
  localparam logic [10:0] OP_STORE = 11'b000_0000_1000;

  logic        clk, rst;
  logic        ce, stall, flush, we, ack;
  logic [10:0] opcode;
  logic [2:0]  funct3;
  logic [31:0] alu, rs2, wb_rdata;
  logic [4:0]  rd;
  logic        wb_cyc, wb_stb, wb_we, o_stall, o_ce, o_we_reg, o_misaligned;
  logic [31:0] wb_addr, wb_wdata, o_data_rd;
  logic [3:0]  wb_sel;
  logic [4:0]  o_addr_rd;

  int n_cmp;
  int n_bad;

  memory_stage #(
    .DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3),
    .OPCODE_WIDTH(11), .LOAD_BIT(2), .STORE_BIT(3)
  ) dut (
    .me_clk(clk), .me_rst(rst),
    .me_i_ce(ce), .me_i_stall(stall), .me_i_flush(flush),
    .me_i_opcode(opcode), .me_i_funct3(funct3),
    .me_i_alu_value(alu), .me_i_data_rs2(rs2),
    .me_i_addr_rd(rd), .me_i_we_reg(we),
    .me_o_wb_cyc(wb_cyc), .me_o_wb_stb(wb_stb), .me_o_wb_we(wb_we),
    .me_o_wb_addr(wb_addr), .me_o_wb_data(wb_wdata), .me_o_wb_sel(wb_sel),
    .me_i_wb_ack(ack), .me_i_wb_data(wb_rdata),
    .me_o_stall(o_stall), .me_o_ce(o_ce), .me_o_we_reg(o_we_reg),
    .me_o_addr_rd(o_addr_rd), .me_o_data_rd(o_data_rd),
    .me_o_misaligned(o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (a[1:0] * 8)) & 32'hFF;
    h = (rdata >> (a[1] * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] ref_sel(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    if (ld) return 4'hF;
    case (f3 % 4)
      0:       return 4'(1 << (a % 4));
      1:       return (a % 4 >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_sdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3 % 4)
      0:       return (v & 32'hFF) * 32'h0101_0101;
      1:       return (v & 32'hFFFF) * 32'h0001_0001;
      default: return v;
    endcase
  endfunction

  function automatic bit ref_ok(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    if (!legal) return 1'b0;
    if (f3 % 4 == 1 && a % 2 != 0) return 1'b0;
    if (f3 % 4 == 2 && a % 4 != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic alu_txn(input logic [10:0] op, input logic [31:0] v, input logic [4:0] r,
                         input logic w);
    opcode = op; funct3 = 3'($urandom); alu = v; rd = r; we = w; ce = 1'b1;
    tick();
    ce = 1'b0;
    check("alu ce", o_ce, 1);
    check("alu data", o_data_rd, v);
    check("alu rd", o_addr_rd, r);
    check("alu we", o_we_reg, w);
    check("alu cyc", wb_cyc, 0);
    check("alu stall", o_stall, 0);
    check("alu misaligned", o_misaligned, 0);
  endtask

  // One memory instruction: ack arrives `delay` cycles after the stb cycle, stall is
  // held for `hold` cycles from the ack cycle, and flush pulses in BUSY cycle flush_at.
  task automatic mem_txn(input logic [10:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] v2, input logic [4:0] r, input logic w,
                         input logic [31:0] rdata, input int delay, input int hold,
                         input int flush_at);
    bit ld;
    int stall_cnt;
    ld = (op == OP_LOAD);
    opcode = op; funct3 = f3; alu = a; rs2 = v2; rd = r; we = w; ce = 1'b1;
    tick();
    ce = 1'b0;
    if (!ref_ok(ld, f3, a)) begin
      check("exc misaligned", o_misaligned, 1);
      check("exc ce", o_ce, 1);
      check("exc we", o_we_reg, 0);
      check("exc cyc", wb_cyc, 0);
      tick();
      check("exc pulse end", o_misaligned, 0);
      check("exc ce end", o_ce, 0);
      return;
    end
    check("req cyc", wb_cyc, 1);
    check("req stb", wb_stb, 1);
    check("req we", wb_we, !ld);
    check("req addr", wb_addr, a & 32'hFFFF_FFFC);
    check("req sel", wb_sel, ref_sel(ld, f3, a));
    if (!ld) check("req data", wb_wdata, ref_sdata(f3, v2));
    check("req ce", o_ce, 0);
    stall_cnt = 0;
    for (int k = 0; k <= delay; k++) begin
      if (k > 0) begin
        check("busy cyc", wb_cyc, 1);
        check("busy stb", wb_stb, 0);
      end
      stall_cnt += int'(o_stall);
      flush = (k == flush_at);
      if (k == delay) begin
        ack = 1'b1; wb_rdata = rdata; stall = (hold > 0);
      end
      tick();
    end
    ack = 1'b0; flush = 1'b0; wb_rdata = $urandom;
    check("done cyc", wb_cyc, 0);
    for (int h = 0; h < hold; h++) begin
      check("hold stall", o_stall, 1);
      check("hold ce", o_ce, 0);
      stall_cnt += int'(o_stall);
      if (h == hold - 1) stall = 1'b0;
      tick();
    end
    check("stall cycles", stall_cnt, delay + 1 + hold);
    check("ret ce", o_ce, flush_at < 0);
    check("ret we", o_we_reg, ld && w && flush_at < 0);
    check("ret rd", o_addr_rd, r);
    check("ret data", o_data_rd, ld ? ref_load(f3, a, rdata) : 32'h0);
    check("ret stall", o_stall, 0);
  endtask

  initial begin
    int kind, dly, hld, fl, idx;
    logic [2:0] f3r;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; ce = 1'b0; stall = 1'b0; flush = 1'b0; ack = 1'b0; we = 1'b0;
    opcode = '0; funct3 = '0; alu = '0; rs2 = '0; rd = '0; wb_rdata = '0;
    #12;
    check("rst cyc", wb_cyc, 0);
    check("rst stb", wb_stb, 0);
    check("rst ce", o_ce, 0);
    check("rst stall", o_stall, 0);
    check("rst data", o_data_rd, 0);
    #5 rst = 1'b1;

    alu_txn(OP_ALU, 32'h1234, 5'd5, 1'b1);
    // Stall in IDLE freezes every output, including o_ce.
    opcode = OP_ALU; alu = 32'h9999; rd = 5'd7; we = 1'b0; ce = 1'b1; stall = 1'b1;
    tick();
    check("idle stall ce", o_ce, 1);
    check("idle stall data", o_data_rd, 32'h1234);
    check("idle stall rd", o_addr_rd, 5);
    ce = 1'b0; stall = 1'b0;
    tick();
    check("bubble ce", o_ce, 0);

    mem_txn(OP_LOAD, 3'd0, 32'h103, 32'h0, 5'd9, 1'b1, 32'h80FF_0000, 2, 0, -1);
    check("lb value", o_data_rd, 32'hFFFF_FF80);
    mem_txn(OP_LOAD, 3'd4, 32'h103, 32'h0, 5'd9, 1'b1, 32'h80FF_0000, 2, 0, -1);
    check("lbu value", o_data_rd, 32'h0000_0080);
    mem_txn(OP_STORE, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'h0, 1, 0, -1);
    mem_txn(OP_LOAD, 3'd2, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, -1);
    mem_txn(OP_LOAD, 3'd2, 32'h40, 32'h0, 5'd6, 1'b1, 32'h1111_2222, 3, 0, 1);
    alu_txn(OP_ALU, 32'hABCD, 5'd8, 1'b1);
    mem_txn(OP_LOAD, 3'd1, 32'h106, 32'h0, 5'd10, 1'b1, 32'h8001_7FFF, 0, 2, -1);
    check("lh hold value", o_data_rd, 32'hFFFF_8001);

    // Asynchronous reset in BUSY, then an ack that must be ignored.
    opcode = OP_LOAD; funct3 = 3'd2; alu = 32'h300; rd = 5'd11; we = 1'b1; ce = 1'b1;
    tick();
    ce = 1'b0;
    check("pre-rst cyc", wb_cyc, 1);
    #3 rst = 1'b0;
    #1;
    check("async cyc", wb_cyc, 0);
    check("async stb", wb_stb, 0);
    check("async stall", o_stall, 0);
    check("async data", o_data_rd, 0);
    check("async rd", o_addr_rd, 0);
    #2 rst = 1'b1; ack = 1'b1; wb_rdata = 32'h5555_AAAA;
    tick();
    ack = 1'b0;
    tick();
    check("late ack cyc", wb_cyc, 0);
    check("late ack ce", o_ce, 0);
    check("late ack data", o_data_rd, 0);
    check("late ack stall", o_stall, 0);

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        idx = $urandom_range(0, 8);
        alu_txn(11'(1 << (idx < 2 ? idx : idx + 2)), $urandom, 5'($urandom), 1'($urandom));
      end else begin
        f3r = 3'($urandom);
        dly = $urandom_range(0, 3);
        hld = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : 0;
        fl  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, dly) : -1;
        mem_txn(kind == 1 ? OP_LOAD : OP_STORE, f3r, $urandom, $urandom, 5'($urandom),
                1'($urandom), $urandom, dly, hld, fl);
      end
      tick();
      check("idle ce", o_ce, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage directly downstream of the execute stage. It takes each retiring instruction from execute, performs data-memory loads and stores over a single-outstanding Wishbone-style request/acknowledge bus, and hands register-writeback information to the writeback stage. While a bus transaction is pending it stalls execute. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- DWIDTH, 32, data and bus width; only 32 is supported.
- AWIDTH, 5, register address width.
- FUNCT_WIDTH, 3, funct3 width.

Ports:
- me_clk  in  1  clock; single clock domain.
- me_rst  in  1  asynchronous, active-low reset.
- me_i_ce  in  1  valid instruction from execute.
- me_i_stall / me_i_flush  in  1  stall or flush from the pipeline control.
- me_i_opcode  in  `OPCODE_WIDTH  one-hot opcode; the `LOAD and `STORE bits select memory operations.
- me_i_funct3  in  FUNCT_WIDTH  access size and sign.
- me_i_alu_value  in  DWIDTH  effective address for memory operations; otherwise the result.
- me_i_data_rs2  in  DWIDTH  store data.
- me_i_addr_rd  in  AWIDTH  destination register.
- me_i_we_reg  in  1  register write enable.
- me_o_wb_cyc, me_o_wb_stb, me_o_wb_we  out  1  bus cycle, strobe, write.
- me_o_wb_addr  out  DWIDTH  word address {addr[31:2],2'b00}.
- me_o_wb_data  out  DWIDTH  write data.
- me_o_wb_sel  out  DWIDTH/8  byte lanes.
- me_i_wb_ack  in  1  transfer complete.
- me_i_wb_data  in  DWIDTH  read data.
- me_o_stall  out  1  stall to execute.
- me_o_ce  out  1  valid result to writeback.
- me_o_we_reg  out  1  write enable to writeback.
- me_o_addr_rd  out  AWIDTH  destination register to writeback.
- me_o_data_rd  out  DWIDTH  data to writeback.
- me_o_misaligned  out  1  one-cycle exception pulse.

## Operation
- State machine states: IDLE, BUSY, HOLD.
- **IDLE.** An instruction is accepted when me_i_ce=1, me_i_stall=0 and me_i_flush=0.
  - Non-memory instruction: at the next edge, o_ce=1, o_data_rd=alu_value, and o_addr_rd and o_we_reg are copied from the inputs. The state stays IDLE.
  - Load or store, aligned, legal funct3: at the next edge, cyc=1 and stb=1, the request registers are loaded, addr_rd and we_reg are captured, o_ce=0, and the state goes to BUSY.
  - Misaligned or illegal access: no bus request is issued. At the next edge, o_ce=1, o_we_reg=0 and o_misaligned=1, and the state stays IDLE.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
    - Illegal funct3: 011, 110 or 111 for loads; anything other than 000, 001 or 010 for stores.
  - No valid instruction accepted: o_ce=0 at the next edge.
- **funct3 encoding:** 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
- **Store lanes and data:**
  - SB: sel = 4'b0001<<addr[1:0], data = {4{rs2[7:0]}}.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011, data = {2{rs2[15:0]}}.
  - SW: sel = 4'b1111.
- **Loads:** sel=4'b1111. The selected byte or half is taken from the lane given by addr[1:0], then sign-extended (LB, LH) or zero-extended (LBU, LHU).
- **BUSY.**
  - stb is high only in the first BUSY cycle; cyc is held until ack.
  - On ack: cyc=0, and the load data (or 0 for a store) goes into a result buffer.
    - If me_i_stall=0: the outputs update (o_ce=1; o_we_reg = captured we_reg for loads, 0 for stores) and the state goes to IDLE.
    - If me_i_stall=1: the state goes to HOLD.
- **HOLD.** The outputs load from the buffer at the first edge where me_i_stall=0, and the state goes to IDLE.
- **me_o_stall** = (state != IDLE).
- **Flush:**
  - In IDLE, flush drops the instruction.
  - In BUSY or HOLD, the bus cycle is never aborted. A sticky squash flag is set instead, and the completing result is emitted with o_ce=0 and o_we_reg=0. The flag clears on return to IDLE.
- **me_i_stall in IDLE:** all outputs hold their values, including o_ce.

## Timing
- Reset (asynchronous): the state goes to IDLE, and every output goes to 0 immediately, including cyc and stb. An ack arriving after reset is ignored.
- Latency:
  - Non-memory: 1 cycle.
  - Memory: stb is visible 1 cycle after acceptance. The result is registered at the ack edge, so the minimum latency is 2 cycles when ack arrives in the stb cycle.
- Only one transaction is outstanding at a time, with no new acceptance while me_o_stall=1.
- me_o_misaligned is a 1-cycle pulse.
- A new instruction may be accepted on the same edge that returns BUSY or HOLD to IDLE only if me_o_stall was low in that cycle. Because me_o_stall is high in that cycle, the next acceptance is one cycle later.

## Test plan
- **ALU pass-through.** Accept a non-memory instruction with alu_value=0x1234, rd=5, we=1 → next cycle o_ce=1, o_data_rd=0x1234, o_addr_rd=5, o_we_reg=1, and the bus stays idle.
- **Signed and unsigned byte load.** LB from address 0x103 with rdata 0x80FF_0000 and ack 2 cycles after stb → sel=4'b1111, o_data_rd=0xFFFF_FF80, me_o_stall high 3 cycles. Repeat as LBU → o_data_rd=0x0000_0080.
- **Halfword store.** SH to 0x202 with rs2=0xDEAD_BEEF → wb_addr=0x200, sel=4'b1100, data=0xBEEF_BEEF, we=1, stb for 1 cycle. On completion, o_ce=1 and o_we_reg=0.
- **Misaligned access.** LW to 0x101 → no cyc. Next cycle o_misaligned=1, o_ce=1, o_we_reg=0; one cycle later o_misaligned=0.
- **Flush during BUSY.** Assert flush while a load is BUSY → cyc is held until ack, then o_ce=0 and o_we_reg=0. The next instruction after flush processes normally.
- **Stall at ack, and reset mid-transaction.**
  - me_i_stall=1 at ack → state HOLD, outputs unchanged until stall drops, then the load data appears.
  - Reset asserted in BUSY → cyc, stb and all outputs 0 at once, and a late ack has no effect.
